pwm_group: RTL and testbench

//  Parametrised N-channel PWM generator group sharing one prescaler and one period counter.
//  Per-channel duty and polarity; edge- or center-aligned counting.

---
 rtl/pwm_group_if.sv | 29 ++
 rtl/pwm_group.sv | 140 ++++++++++++++
 tb/tb_pwm_group.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_group_if.sv
// Configuration and output bundle of one PWM channel group.
// The master side drives the configuration. The slave side is the PWM generator.
interface pwm_group_if #(
    parameter int unsigned CH_NUM = 8,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PSC_W  = 16
);
    logic                     en;
    logic                     cfg_load;
    logic [PSC_W-1:0]         psc;
    logic [CNT_W-1:0]         period;
    logic [CH_NUM*CNT_W-1:0]  duty;
    logic [CH_NUM-1:0]        polarity;
    logic                     center_mode;
    logic [CH_NUM-1:0]        pwm_out;
    logic                     period_tick;
    logic [CNT_W-1:0]         cnt;
    logic                     cfg_pending;

    modport master (
        output en, cfg_load, psc, period, duty, polarity, center_mode,
        input  pwm_out, period_tick, cnt, cfg_pending
    );

    modport slave (
        input  en, cfg_load, psc, period, duty, polarity, center_mode,
        output pwm_out, period_tick, cnt, cfg_pending
    );
endinterface

// File: rtl/pwm_group.sv
// N-channel PWM group: one shared prescaler and period counter, per-channel compare.
// Configuration is shadowed and becomes active at a period boundary, or at any time while disabled.
module pwm_group #(
    parameter int unsigned CH_NUM = 8,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PSC_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pwm_group_if.slave  bus
);

    typedef struct packed {
        logic [PSC_W-1:0]        psc;
        logic [CNT_W-1:0]        period;
        logic [CH_NUM*CNT_W-1:0] duty;
        logic [CH_NUM-1:0]       polarity;
        logic                    center;
    } cfg_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    cfg_t              act_q, act_d, pend_q, pend_d, cfg_in;
    logic              pending_q, pending_d;
    logic [PSC_W-1:0]  psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_step;
    dir_t              dir_q, dir_d, dir_step;
    logic [CH_NUM-1:0] pwm_q, pwm_d, raw;
    logic              tick_q, tick_d;
    logic              step, boundary, transfer;

    always_comb begin
        cfg_in          = '0;
        cfg_in.psc      = bus.psc;
        cfg_in.period   = bus.period;
        cfg_in.duty     = bus.duty;
        cfg_in.polarity = bus.polarity;
        cfg_in.center   = bus.center_mode;
    end

    // Per-channel compare against the active duty values
    always_comb begin
        raw = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            raw[i] = (cnt_q < act_q.duty[i*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            psc_cnt_q <= '0;
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            pwm_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            act_q     <= act_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            pwm_q     <= pwm_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        act_d     = act_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        psc_cnt_d = psc_cnt_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        pwm_d     = act_q.polarity;
        tick_d    = 1'b0;
        cnt_step  = cnt_q;
        dir_step  = dir_q;
        step      = 1'b0;
        boundary  = 1'b0;

        // Counter position after the next step; a zero period always counts as edge-aligned
        if (!act_q.center || act_q.period == '0) begin
            cnt_step = (cnt_q >= act_q.period) ? '0 : cnt_q + CNT_W'(1);
            dir_step = DIR_UP;
        end else if (dir_q == DIR_UP && cnt_q < act_q.period) begin
            cnt_step = cnt_q + CNT_W'(1);
        end else begin
            cnt_step = cnt_q - CNT_W'(1);
            dir_step = DIR_DOWN;
        end
        if (cnt_step == '0) begin
            dir_step = DIR_UP;
        end

        if (bus.en) begin
            step      = (psc_cnt_q >= act_q.psc);
            psc_cnt_d = step ? '0 : psc_cnt_q + PSC_W'(1);
            pwm_d     = raw ^ act_q.polarity;
            if (step) begin
                cnt_d    = cnt_step;
                dir_d    = dir_step;
                boundary = (cnt_step == '0);
            end
            tick_d = boundary;
        end else begin
            psc_cnt_d = '0;
            cnt_d     = '0;
            dir_d     = DIR_UP;
        end

        // A load coinciding with a transfer bypasses the pending registers
        transfer = boundary || !bus.en;
        if (bus.cfg_load) begin
            pend_d = cfg_in;
        end
        if (transfer) begin
            pending_d = 1'b0;
            if (bus.cfg_load) begin
                act_d = cfg_in;
            end else if (pending_q) begin
                act_d = pend_q;
            end
        end else if (bus.cfg_load) begin
            pending_d = 1'b1;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_tick = tick_q;
    assign bus.cnt         = cnt_q;
    assign bus.cfg_pending = pending_q;

endmodule

// File: tb/tb_pwm_group.sv
// Randomised bench for pwm_group. A phase-index reference model supplies expected outputs every cycle.
module tb_pwm_group;
    localparam int unsigned CH_NUM = 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PSC_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_group_if #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .PSC_W(PSC_W)) bus ();

    pwm_group #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint unsigned         psc;
        longint unsigned         period;
        logic [CH_NUM*CNT_W-1:0] duty;
        logic [CH_NUM-1:0]       pol;
        bit                      center;
    } mcfg_t;

    int n_checks = 0;
    int n_errors = 0;

    mcfg_t             m_act, m_pend;
    bit                m_pending;
    longint unsigned   m_sub, m_pos;
    logic [CH_NUM-1:0] e_pwm;
    bit                e_tick;
    longint unsigned   e_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Steps in one full period: up-only, or up-and-down with unrepeated turning points
    function automatic longint unsigned period_len(input mcfg_t c);
        if (!c.center || c.period == 0) return c.period + 1;
        return 2 * c.period;
    endfunction

    function automatic longint unsigned pos_to_cnt(input mcfg_t c, input longint unsigned p);
        if (!c.center || p <= c.period) return p;
        return 2 * c.period - p;
    endfunction

    function automatic mcfg_t cfg_from_inputs();
        mcfg_t c;
        c.psc    = 64'(bus.psc);
        c.period = 64'(bus.period);
        c.duty   = bus.duty;
        c.pol    = bus.polarity;
        c.center = bus.center_mode;
        return c;
    endfunction

    task automatic model_reset();
        m_act.psc = 0; m_act.period = 0; m_act.duty = '0; m_act.pol = '0; m_act.center = 1'b0;
        m_pend    = m_act;
        m_pending = 1'b0;
        m_sub     = 0;
        m_pos     = 0;
        e_pwm     = '0;
        e_tick    = 1'b0;
        e_cnt     = 0;
    endtask

    task automatic model_step();
        logic [CH_NUM-1:0] raw;
        longint unsigned   cur;
        bit                stp, bnd, transfer;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cur = pos_to_cnt(m_act, m_pos);
        for (int i = 0; i < int'(CH_NUM); i++) begin
            raw[i] = (cur < 64'(m_act.duty[i*CNT_W +: CNT_W]));
        end
        bnd = 1'b0;
        if (bus.en) begin
            e_pwm = raw ^ m_act.pol;
            stp   = (m_sub == m_act.psc);
            m_sub = stp ? 0 : m_sub + 1;
            if (stp) begin
                m_pos = (m_pos + 1) % period_len(m_act);
                bnd   = (m_pos == 0);
            end
        end else begin
            e_pwm = m_act.pol;
            m_sub = 0;
            m_pos = 0;
        end
        e_tick   = bnd;
        transfer = bnd || !bus.en;
        if (transfer) begin
            if (bus.cfg_load) m_act = cfg_from_inputs();
            else if (m_pending) m_act = m_pend;
            m_pending = 1'b0;
        end else if (bus.cfg_load) begin
            m_pend    = cfg_from_inputs();
            m_pending = 1'b1;
        end
        e_cnt = pos_to_cnt(m_act, m_pos);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge, load pulse dropped
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pwm_out", 64'(bus.pwm_out), 64'(e_pwm));
        check("cnt", 64'(bus.cnt), e_cnt);
        check("period_tick", 64'(bus.period_tick), 64'(e_tick));
        check("cfg_pending", 64'(bus.cfg_pending), 64'(m_pending));
        bus.cfg_load = 1'b0;
    endtask

    task automatic count_window(input int ch, input int n, output int hi, output int ticks);
        hi = 0;
        ticks = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            if (bus.pwm_out[ch]) hi++;
            if (bus.period_tick) ticks++;
        end
    endtask

    task automatic load(input int psc, input int period, input logic [CH_NUM*CNT_W-1:0] d,
                        input logic [CH_NUM-1:0] pol, input bit center);
        bus.psc         = PSC_W'(psc);
        bus.period      = CNT_W'(period);
        bus.duty        = d;
        bus.polarity    = pol;
        bus.center_mode = center;
        bus.cfg_load    = 1'b1;
        cycle();
    endtask

    initial begin
        logic [CH_NUM*CNT_W-1:0] d;
        int hi, ticks;
        bit found;

        bus.en = 1'b0; bus.cfg_load = 1'b0; bus.psc = '0; bus.period = '0;
        bus.duty = '0; bus.polarity = '0; bus.center_mode = 1'b0;
        model_reset();

        cycle();
        cycle();
        check("rst_pwm_out", 64'(bus.pwm_out), 64'd0);
        check("rst_cnt", 64'(bus.cnt), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Edge mode, duty 3 of period 10
        d = '0;
        d[0*CNT_W +: CNT_W] = CNT_W'(3);
        load(0, 9, d, '0, 1'b0);
        bus.en = 1'b1;
        repeat (12) cycle();
        count_window(0, 10, hi, ticks);
        check("edge_high_time", 64'(hi), 64'd3);
        check("edge_tick_count", 64'(ticks), 64'd1);

        // Shadowed duty update mid-period
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus.cnt == CNT_W'(4)) found = 1'b1;
            else cycle();
        end
        check("wait_cnt4", 64'(found), 64'd1);
        d[0*CNT_W +: CNT_W] = CNT_W'(7);
        load(0, 9, d, '0, 1'b0);
        check("shadow_pending", 64'(bus.cfg_pending), 64'd1);
        repeat (15) cycle();
        check("shadow_cleared", 64'(bus.cfg_pending), 64'd0);
        count_window(0, 10, hi, ticks);
        check("shadow_high_time", 64'(hi), 64'd7);

        // Center mode: period 32 clk, channel 1 high for 12
        d[1*CNT_W +: CNT_W] = CNT_W'(2);
        load(3, 4, d, '0, 1'b1);
        repeat (64) cycle();
        count_window(1, 32, hi, ticks);
        check("center_high_time", 64'(hi), 64'd12);
        check("center_tick_count", 64'(ticks), 64'd1);

        // Duty extremes with inversion
        d = '0;
        d[3*CNT_W +: CNT_W] = CNT_W'(10);
        load(0, 9, d, 8'b0000_1000, 1'b0);
        repeat (25) cycle();
        count_window(2, 20, hi, ticks);
        check("duty0_never_active", 64'(hi), 64'd0);
        count_window(3, 20, hi, ticks);
        check("duty_over_inverted", 64'(hi), 64'd0);

        // Disable for 5 clk, then restart
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("idle_pwm_level", 64'(bus.pwm_out), 64'h08);
            check("idle_cnt", 64'(bus.cnt), 64'd0);
        end
        bus.en = 1'b1;
        cycle();
        check("restart_first_step", 64'(bus.cnt), 64'd1);

        // Random configuration traffic
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int c = 0; c < int'(CH_NUM); c++) begin
                    bus.duty[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
                end
                bus.psc         = PSC_W'($urandom_range(0, 3));
                bus.period      = CNT_W'($urandom_range(0, 12));
                bus.polarity    = CH_NUM'($urandom);
                bus.center_mode = 1'($urandom_range(0, 1));
                bus.cfg_load    = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) bus.en = ~bus.en;
            cycle();
        end

        // Asynchronous reset in the middle of a period
        d = '0;
        d[0*CNT_W +: CNT_W] = CNT_W'(15);
        bus.en = 1'b0;
        load(0, 9, d, '0, 1'b0);
        bus.en = 1'b1;
        repeat (6) cycle();
        check("pre_reset_active", 64'(bus.pwm_out[0]), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm_out", 64'(bus.pwm_out), 64'd0);
        check("async_rst_cnt", 64'(bus.cnt), 64'd0);
        check("async_rst_tick", 64'(bus.period_tick), 64'd0);
        model_reset();
        bus.en = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("post_reset_pwm_out", 64'(bus.pwm_out), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
